// File: rtl/mipi_byte_aligner.sv
`default_nettype none
// ============================================================================
//  Module   : mipi_byte_aligner
//  Purpose  : Realigns the raw byte stream of a MIPI HS lane to the bit
//             offset of the 0xB8 sync byte and emits the payload bytes.
//             An external detector inspects {curr_byte, last_byte} and
//             reports the hit and its bit offset.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk             block clock, rising edge
//    rst_n           asynchronous active-low reset
//    i_byte_in[7:0]  raw unaligned byte from the lane deserializer
//    i_byte_en       byte valid / HS burst active (low = burst ended)
//    i_found_hdr     detector hit on the sync byte
//    i_hdr_offs[2:0] detector bit offset of the sync byte
//    o_curr_byte     to detector, combinational copy of i_byte_in
//    o_last_byte     to detector, previous byte of the burst
//    o_aligned_byte  realigned payload byte
//    o_aligned_valid one-cycle qualifier for o_aligned_byte
//    o_sot           one-cycle pulse, sync byte accepted
//    o_locked        high while locked to a burst
//    o_sync_err      one-cycle pulse, no sync byte within the hunt window
//    o_byte_cnt      payload bytes emitted in the current burst (saturating)
// ============================================================================
module mipi_byte_aligner #(
  parameter int HUNT_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  i_byte_in,
  input  logic        i_byte_en,
  input  logic        i_found_hdr,
  input  logic [2:0]  i_hdr_offs,
  output logic [7:0]  o_curr_byte,
  output logic [7:0]  o_last_byte,
  output logic [7:0]  o_aligned_byte,
  output logic        o_aligned_valid,
  output logic        o_sot,
  output logic        o_locked,
  output logic        o_sync_err,
  output logic [15:0] o_byte_cnt
);

  localparam logic [7:0] c_TIMEOUT = 8'(HUNT_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HUNT   = 2'd1,
    S_LOCKED = 2'd2,
    S_ERROR  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [7:0]  r_last;
  logic [2:0]  r_k;
  logic [7:0]  r_hunt_cnt;
  logic [7:0]  r_aligned_byte;
  logic        r_aligned_valid;
  logic        r_sot;
  logic        r_locked;
  logic        r_sync_err;
  logic [15:0] r_byte_cnt;

  logic        w_hunt_cycle;
  logic        w_lock_cycle;
  logic        w_hit;
  logic        w_timeout;
  logic [7:0]  w_hunt_cnt_inc;
  logic [15:0] w_window;

  // Newest byte in the upper half so a byte straddling two transfers is
  // picked up by a plain offset slice.
  assign w_window = {i_byte_in, r_last};

  // ------------------------------------------------------------------------
  // State register
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ------------------------------------------------------------------------
  // Next-state logic. The IDLE entry cycle is processed exactly like a
  // HUNT cycle so the first byte of a burst is not lost to the detector.
  // ------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_hunt_cycle   = 1'b0;
    w_lock_cycle   = 1'b0;
    w_hit          = 1'b0;
    w_timeout      = 1'b0;
    w_hunt_cnt_inc = (r_state == S_HUNT) ? (r_hunt_cnt + 8'd1) : 8'd1;

    if (!i_byte_en) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_HUNT: begin
          w_hunt_cycle = 1'b1;
          // A hit on the last allowed byte still locks.
          if (i_found_hdr) begin
            w_hit       = 1'b1;
            w_state_nxt = S_LOCKED;
          end else if (w_hunt_cnt_inc == c_TIMEOUT) begin
            w_timeout   = 1'b1;
            w_state_nxt = S_ERROR;
          end else begin
            w_state_nxt = S_HUNT;
          end
        end
        S_LOCKED: begin
          w_lock_cycle = 1'b1;
        end
        S_ERROR: begin
          w_state_nxt = S_ERROR;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // ------------------------------------------------------------------------
  // Datapath and registered outputs
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last          <= 8'h00;
      r_k             <= 3'd0;
      r_hunt_cnt      <= 8'd0;
      r_aligned_byte  <= 8'h00;
      r_aligned_valid <= 1'b0;
      r_sot           <= 1'b0;
      r_locked        <= 1'b0;
      r_sync_err      <= 1'b0;
      r_byte_cnt      <= 16'd0;
    end else begin
      r_sot           <= w_hit;
      r_sync_err      <= w_timeout;
      r_aligned_valid <= w_lock_cycle;
      r_locked        <= (w_state_nxt == S_LOCKED);

      // Clearing on burst end guarantees the next burst's entry cycle
      // sees an all-zero previous byte.
      if (!i_byte_en) begin
        r_last     <= 8'h00;
        r_hunt_cnt <= 8'd0;
      end else if (w_hunt_cycle || w_lock_cycle) begin
        r_last <= i_byte_in;
      end

      if (w_hunt_cycle) begin
        r_hunt_cnt <= w_hunt_cnt_inc;
      end

      if (w_hit) begin
        r_k        <= i_hdr_offs;
        r_byte_cnt <= 16'd0;
      end

      if (w_lock_cycle) begin
        r_aligned_byte <= w_window[{1'b0, r_k} +: 8];
        if (r_byte_cnt != 16'hFFFF) begin
          r_byte_cnt <= r_byte_cnt + 16'd1;
        end
      end
    end
  end

  assign o_curr_byte     = i_byte_in;
  assign o_last_byte     = r_last;
  assign o_aligned_byte  = r_aligned_byte;
  assign o_aligned_valid = r_aligned_valid;
  assign o_sot           = r_sot;
  assign o_locked        = r_locked;
  assign o_sync_err      = r_sync_err;
  assign o_byte_cnt      = r_byte_cnt;

endmodule
`default_nettype wire
